croc_vec_player: RTL
====================

// Module: croc_vec_player
// PURPOSE
// - Hardware vector-replay sequencer for croc_soc chip IO: streams stimulus/expect vectors,
//   drives DUT inputs at a fixed apply phase, samples DUT outputs at a fixed test phase.
// - Expect check is one vector delayed: outputs seen in period N are compared with expect of vector N-1.
// - Counts mismatching periods and latches the first failing index. Sits between a vector source
//   (DMA/FIFO) and chip pads on FPGA or emulation.
// PARAMETERS
// - PERIOD_CYC  10   clk_i cycles per vector period (>=3)
// - APPL_CYC    2    phase at which a vector is accepted and driven (< TEST_CYC)
// - TEST_CYC    8    phase at which dut_out_i is compared (< PERIOD_CYC)
// - IN_W        26   stimulus width (ctrl 10 + gpio 16)
// - OUT_W       35   expect width (status, tdo, tx, gpio 16, gpio_oe 16)
// - CNT_W       32   width of index/mismatch counters
// - IDLE_VEC    '0   value of dut_in_o at reset and outside a run
// PORTS
// - clk_i             in  1      clock
// - rst_ni            in  1      asynchronous active-low reset
// - start_i           in  1      pulse: begin a run (ignored while busy_o)
// - vec_valid_i       in  1      vector available
// - vec_ready_o       out 1      vector accepted when valid & ready
// - vec_in_i          in  IN_W   stimulus for DUT
// - vec_exp_i         in  OUT_W  expected DUT outputs
// - vec_last_i        in  1      this vector is the final one
// - dut_in_o          out IN_W   registered DUT stimulus
// - dut_out_i         in  OUT_W  DUT outputs
// - busy_o / done_o   out 1      run active / run finished (sticky until next start)
// - vec_idx_o         out CNT_W  vectors accepted this run
// - mismatch_cnt_o    out CNT_W  periods failing compare (saturating)
// - first_err_vld_o   out 1      first_err_idx_o valid
// - first_err_idx_o   out CNT_W  vec_idx of first failing check
// - underrun_cnt_o    out CNT_W  cycles stalled waiting for vec_valid_i (saturating)
// BEHAVIOUR
// - Reset: IDLE, dut_in_o=IDLE_VEC, all status outputs and counters 0, vec_ready_o=0.
// - FSM IDLE -> RUN on start_i (clears counters, done_o, first_err, exp_vld; phase=0).
// - RUN: phase counts 0..PERIOD_CYC-1, wraps. vec_ready_o=1 only while phase==APPL_CYC.
//   At APPL_CYC: if valid -> dut_in_o<=vec_in_i next cycle, exp_nxt<=vec_exp_i, vec_idx++;
//   else phase holds, underrun++. vec_last_i captured into last_q.
// - At TEST_CYC: if exp_vld, compare dut_out_i vs exp_q; on mismatch mismatch_cnt++,
//   and if !first_err_vld latch first_err_idx=vec_idx_o-1. Next cycle exp_q<=exp_nxt, exp_vld<=1.
// - After the TEST_CYC of the period in which last_q was accepted -> DRAIN: one further period,
//   no handshake, dut_in_o holds, compare at TEST_CYC against last vector's expect -> DONE.
// - DONE: done_o=1, busy_o=0, dut_in_o<=IDLE_VEC; start_i -> RUN. busy_o=1 in RUN/DRAIN.
// - First vector: no compare in its period. Counters saturate at all-ones, no wrap.
// - start_i in RUN/DRAIN ignored. Reset mid-run: immediate return to reset state.
// CONFIGURATION
// - CROC_VEC_PLAYER_MASK_EN defined: adds vec_mask_i (in, OUT_W); bit=1 excludes the bit
//   from compare; mask pipelined alongside exp_q. Undefined: port absent, all bits compared.
// STRUCTURE
// - croc_vec_player_pkg: state enum (IDLE, RUN, DRAIN, DONE), phase_t sized $clog2(PERIOD_CYC),
//   saturating-increment function.
// - Sub-module croc_vec_cmp: registered-free masked compare, outputs single mismatch bit.
// TESTING
// - 3 vectors, dut_out_i looped to expect, defaults -> done_o after 4 periods (40+ cycles), mismatch_cnt=0.
// - Vector 2 expect 35'h1 vs dut_out 35'h0 -> mismatch_cnt=1, first_err_idx=2, first_err_vld=1.
// - Hold vec_valid_i low 5 cycles at APPL_CYC -> underrun_cnt=5, phase frozen, no compare skipped.
// - Single vector with vec_last_i=1 -> DRAIN checks its expect, done_o after 2 periods.
// - rst_ni low in mid-run -> dut_in_o=IDLE_VEC, counters 0, busy_o=0 asynchronously.
// - MASK_EN: expect 35'h3, dut 35'h1, mask 35'h2 -> mismatch_cnt stays 0.

Source files
------------

// File: rtl/croc_vec_player_pkg.sv
// croc_vec_player_pkg
// Shared types and helpers for the croc_vec_player vector-replay sequencer.
// Contents:
//   - default configuration constants
//   - state_e : sequencer state (IDLE, RUN, DRAIN, DONE)
//   - phase_t : in-period cycle counter type for the default period length
//   - cnt_t   : counter type for index / mismatch / underrun counters
//   - sat_inc : saturating increment (sticks at all-ones)
// Optional feature macro used by the design files: CROC_VEC_PLAYER_MASK_EN.
package croc_vec_player_pkg;

    localparam int PERIOD_CYC_DEF = 10;
    localparam int APPL_CYC_DEF   = 2;
    localparam int TEST_CYC_DEF   = 8;
    localparam int IN_W_DEF       = 26;
    localparam int OUT_W_DEF      = 35;
    localparam int CNT_W_DEF      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [$clog2(PERIOD_CYC_DEF)-1:0] phase_t;
    typedef logic [CNT_W_DEF-1:0]              cnt_t;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/croc_vec_cmp.sv
// croc_vec_cmp
// Purely combinational masked compare between observed and expected DUT outputs.
// Ports:
//   observed : W  sampled DUT outputs
//   expected : W  expected DUT outputs
//   mask     : W  bit=1 removes that bit from the compare
//   mismatch : 1  high when any unmasked bit differs
// The mask input is tied to zero by the top when CROC_VEC_PLAYER_MASK_EN is undefined.
module croc_vec_cmp #(
    parameter int W = 35
) (
    input  logic [W-1:0] observed,
    input  logic [W-1:0] expected,
    input  logic [W-1:0] mask,
    output logic         mismatch
);

    assign mismatch = |((observed ^ expected) & ~mask);

endmodule

// File: rtl/croc_vec_player.sv
// croc_vec_player
// Vector-replay sequencer for croc_soc chip IO. Vectors are accepted once per
// period at phase APPL_CYC and driven onto dut_in_o; DUT outputs are compared at
// phase TEST_CYC against the expect of the previously accepted vector. After the
// period of the last vector a DRAIN period checks the final expect, then DONE.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                begin a run (ignored while busy_o)
//   vec_valid_i/vec_ready_o vector handshake; a vector transfers on a cycle where
//                          both are high. ready is high only at phase APPL_CYC in RUN,
//                          valid may be asserted at any time and is only sampled then.
//   vec_in_i, vec_exp_i, vec_last_i  vector payload
//   dut_in_o               registered stimulus, IDLE_VEC outside a run
//   dut_out_i              DUT outputs
//   busy_o, done_o         run active / run finished (sticky until next start)
//   vec_idx_o              vectors accepted this run
//   mismatch_cnt_o         failing compare periods (saturating)
//   first_err_vld_o/first_err_idx_o  first failing check, idx = vec_idx_o-1 at that check
//   underrun_cnt_o         cycles stalled at APPL_CYC without a vector (saturating)
//   vec_mask_i             compare mask, present only with CROC_VEC_PLAYER_MASK_EN
//   state_o                current sequencer state (debug)
module croc_vec_player
    import croc_vec_player_pkg::*;
#(
    parameter int              PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int              APPL_CYC   = APPL_CYC_DEF,
    parameter int              TEST_CYC   = TEST_CYC_DEF,
    parameter int              IN_W       = IN_W_DEF,
    parameter int              OUT_W      = OUT_W_DEF,
    parameter int              CNT_W      = CNT_W_DEF,
    parameter logic [IN_W-1:0] IDLE_VEC   = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [IN_W-1:0]  vec_in_i,
    input  logic [OUT_W-1:0] vec_exp_i,
    input  logic             vec_last_i,
    output logic [IN_W-1:0]  dut_in_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] vec_idx_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic             first_err_vld_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [CNT_W-1:0] underrun_cnt_o,
`ifdef CROC_VEC_PLAYER_MASK_EN
    input  logic [OUT_W-1:0] vec_mask_i,
`endif
    output state_e           state_o
);

    localparam int PH_W = $clog2(PERIOD_CYC);

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d, phase_inc;
    logic [IN_W-1:0]  dut_in_q;
    logic [OUT_W-1:0] exp_nxt_q, exp_q, cmp_mask;
    logic             exp_vld_q, last_q, first_err_vld_q;
    cnt_t             vec_idx_q, mismatch_q, underrun_q, first_err_idx_q;

    logic at_appl, at_test, start_run, accept, stall, test_strobe, do_cmp, cmp_mismatch;

    assign at_appl     = (phase_q == PH_W'(APPL_CYC));
    assign at_test     = (phase_q == PH_W'(TEST_CYC));
    assign phase_inc   = (phase_q == PH_W'(PERIOD_CYC - 1)) ? '0 : phase_q + PH_W'(1);
    assign start_run   = start_i && (state_q == IDLE || state_q == DONE);
    assign accept      = (state_q == RUN) && at_appl && vec_valid_i;
    assign stall       = (state_q == RUN) && at_appl && !vec_valid_i;
    assign test_strobe = (state_q == RUN || state_q == DRAIN) && at_test;
    assign do_cmp      = test_strobe && exp_vld_q;

    // State and phase registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state / next phase. Phase freezes on an underrun so the test point
    // of the period is delayed rather than skipped.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                if (!stall) phase_d = phase_inc;
                if (test_strobe && last_q) state_d = DRAIN;
            end
            DRAIN: begin
                phase_d = phase_inc;
                if (at_test) begin
                    state_d = DONE;
                    phase_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CROC_VEC_PLAYER_MASK_EN
    // Mask travels through the same two-stage pipeline as the expect.
    logic [OUT_W-1:0] mask_nxt_q, mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_nxt_q <= '0;
            mask_q     <= '0;
        end else if (!start_run) begin
            if (accept)      mask_nxt_q <= vec_mask_i;
            if (test_strobe) mask_q     <= mask_nxt_q;
        end
    end

    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '0;
`endif

    croc_vec_cmp #(.W(OUT_W)) u_cmp (
        .observed (dut_out_i),
        .expected (exp_q),
        .mask     (cmp_mask),
        .mismatch (cmp_mismatch)
    );

    // Datapath: stimulus, expect pipeline (exp_nxt_q -> exp_q at each test
    // point gives the one-vector delay), counters and first-error latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dut_in_q        <= IDLE_VEC;
            exp_nxt_q       <= '0;
            exp_q           <= '0;
            exp_vld_q       <= 1'b0;
            last_q          <= 1'b0;
            vec_idx_q       <= '0;
            mismatch_q      <= '0;
            underrun_q      <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
        end else if (start_run) begin
            exp_vld_q       <= 1'b0;
            last_q          <= 1'b0;
            vec_idx_q       <= '0;
            mismatch_q      <= '0;
            underrun_q      <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
        end else begin
            if (accept) begin
                dut_in_q  <= vec_in_i;
                exp_nxt_q <= vec_exp_i;
                vec_idx_q <= sat_inc(vec_idx_q);
                last_q    <= vec_last_i;
            end
            if (stall) underrun_q <= sat_inc(underrun_q);
            if (do_cmp && cmp_mismatch) begin
                mismatch_q <= sat_inc(mismatch_q);
                if (!first_err_vld_q) begin
                    first_err_vld_q <= 1'b1;
                    first_err_idx_q <= vec_idx_q - cnt_t'(1);
                end
            end
            if (test_strobe) begin
                exp_q     <= exp_nxt_q;
                exp_vld_q <= 1'b1;
            end
            if (state_q == DRAIN && at_test) dut_in_q <= IDLE_VEC;
        end
    end

    assign vec_ready_o     = (state_q == RUN) && at_appl;
    assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
    assign done_o          = (state_q == DONE);
    assign dut_in_o        = dut_in_q;
    assign vec_idx_o       = vec_idx_q;
    assign mismatch_cnt_o  = mismatch_q;
    assign underrun_cnt_o  = underrun_q;
    assign first_err_vld_o = first_err_vld_q;
    assign first_err_idx_o = first_err_idx_q;
    assign state_o         = state_q;

endmodule
